// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings and the SRAM slave control states.
package ahb2_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DP    = 3'd1,
        ST_RD_DP    = 3'd2,
        ST_RD_STALL = 3'd3,
        ST_ERR1     = 3'd4,
        ST_ERR2     = 3'd5
    } slave_state_e;

endpackage

// File: rtl/ahb2_wbe_gen.sv
// Little-endian byte-lane strobes plus size/alignment checks for one AHB transfer.
module ahb2_wbe_gen
    import ahb2_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 32,
    localparam int unsigned STRB_W     = DATA_WIDTH / 8,
    localparam int unsigned OFF_W      = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  addr_lo,
    input  logic [2:0]        hsize,
    output logic [STRB_W-1:0] wbe,
    output logic              size_err,
    output logic              align_err
);

    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    logic [STRB_W-1:0] lanes;
    logic [OFF_W-1:0]  align_mask;

    // Contiguous lane mask for the transfer size, before shifting into place.
    always_comb begin
        lanes = '1;
        case (hsize)
            HSIZE_BYTE:  lanes = STRB_W'(1);
            HSIZE_HWORD: lanes = STRB_W'(3);
            HSIZE_WORD:  lanes = STRB_W'(15);
            default:     lanes = '1;
        endcase
    end

    assign align_mask = OFF_W'((32'd1 << hsize) - 32'd1);
    assign wbe        = lanes << addr_lo;
    assign size_err   = hsize > MAX_SIZE;
    assign align_err  = |(addr_lo & align_mask);

endmodule

// File: rtl/ahb2_sram_slave.sv
// AHB2 slave bridging to a single-port synchronous SRAM; zero-wait writes and reads,
// with one stall when a read address phase collides with a write data phase.
module ahb2_sram_slave
    import ahb2_pkg::*;
#(
    parameter int unsigned  ADDR_WIDTH = 32,
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  MEM_BYTES  = 4096,
    localparam int unsigned STRB_W     = DATA_WIDTH / 8,
    localparam int unsigned OFF_W      = $clog2(STRB_W),
    localparam int unsigned WADDR_W    = $clog2(MEM_BYTES / STRB_W)
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [WADDR_W-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic [STRB_W-1:0]     sram_wbe,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    slave_state_e       state_q, state_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;
    logic [STRB_W-1:0]  wbe_q, wbe_d;

    logic [STRB_W-1:0]  wbe_c;
    logic [WADDR_W-1:0] haddr_word;
    logic               size_err, align_err, range_err;
    logic               can_accept, accept, xfer_err;
    logic               rd_req, wr_req, err_req;
    logic               unused_ok;

    assign unused_ok = ^{hburst, hprot};

    ahb2_wbe_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wbe_gen (
        .addr_lo   (haddr[OFF_W-1:0]),
        .hsize     (hsize),
        .wbe       (wbe_c),
        .size_err  (size_err),
        .align_err (align_err)
    );

    // Address-phase decode; reset gating keeps the read strobe quiet while held in reset.
    assign haddr_word = haddr[OFF_W +: WADDR_W];
    assign can_accept = state_q inside {ST_IDLE, ST_WR_DP, ST_RD_DP, ST_ERR2};
    assign accept     = hreset_n && can_accept && hsel && hready &&
                        ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign range_err  = haddr >= ADDR_WIDTH'(MEM_BYTES);
    assign xfer_err   = range_err || size_err || align_err;
    assign rd_req     = accept && !hwrite && !xfer_err;
    assign wr_req     = accept &&  hwrite && !xfer_err;
    assign err_req    = accept && xfer_err;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            wbe_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wbe_q   <= wbe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        wbe_d      = wbe_q;
        hreadyout  = 1'b1;
        hresp      = HRESP_OKAY;
        hrdata     = '0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wbe   = '0;

        if (accept) begin
            waddr_d = haddr_word;
            wbe_d   = hwrite ? wbe_c : '0;
        end

        case (state_q)
            ST_WR_DP: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = waddr_q;
                sram_wdata = hwdata;
                sram_wbe   = wbe_q;
            end
            ST_RD_DP: hrdata = sram_rdata;
            ST_RD_STALL: begin
                hreadyout = 1'b0;
                sram_cs   = 1'b1;
                sram_addr = waddr_q;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase

        // Reads strobe early unless a write data phase owns the port this cycle.
        if (rd_req && (state_q != ST_WR_DP)) begin
            sram_cs   = 1'b1;
            sram_addr = haddr_word;
        end

        case (state_q)
            ST_RD_STALL: state_d = ST_RD_DP;
            ST_ERR1:     state_d = ST_ERR2;
            default: begin
                if (err_req)     state_d = ST_ERR1;
                else if (wr_req) state_d = ST_WR_DP;
                else if (rd_req) state_d = (state_q == ST_WR_DP) ? ST_RD_STALL : ST_RD_DP;
                else             state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ahb2_sram_slave.md
AHB2_SRAM_SLAVE -- requirements
Module: ahb2_sram_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: AHB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: AHB/SRAM data width; legal values are 32 and 64.
REQ-003 The block SHALL have parameter MEM_BYTES, default 4096: addressable SRAM bytes; must be a power of two.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports hclk (input, 1, rising-edge clock) and hreset_n (input, 1, async active-low reset).
REQ-005 The block SHALL have these AHB inputs: hsel (1); haddr (ADDR_WIDTH); htrans (2); hwrite (1); hsize (3); hburst (3, ignored); hprot (4, ignored); hwdata (DATA_WIDTH); hready (1, bus-level ready).
REQ-006 The block SHALL have these AHB outputs: hreadyout (1); hresp (2); hrdata (DATA_WIDTH).
REQ-007 The block SHALL have these SRAM-side ports: sram_cs (output, 1); sram_we (output, 1); sram_addr (output, log2(MEM_BYTES/(DATA_WIDTH/8)), word address); sram_wdata (output, DATA_WIDTH); sram_wbe (output, DATA_WIDTH/8); sram_rdata (input, DATA_WIDTH, valid one cycle after a read strobe).

Function
REQ-008 The block SHALL accept a transfer only when hsel=1, hready=1 and htrans is NONSEQ(10) or SEQ(11), registering haddr, hwrite and hsize as the pending data phase.
REQ-009 IDLE(00) and BUSY(01) transfers SHALL get a zero-wait OKAY response with no SRAM access.
REQ-010 A transfer SHALL be flagged as an error if any of these hold: haddr >= MEM_BYTES; hsize > log2(DATA_WIDTH/8); or haddr is not aligned to 2^hsize.
REQ-011 An error transfer SHALL produce the two-cycle AHB2 ERROR response: first cycle hresp=01 with hreadyout=0, second cycle hresp=01 with hreadyout=1; it SHALL cause no SRAM access.
REQ-012 A write SHALL complete with zero wait states: in the data-phase cycle, sram_cs=1, sram_we=1, sram_addr is the registered word address, sram_wdata=hwdata, and hreadyout=1 with hresp=00.
REQ-013 sram_wbe SHALL be little-endian: (2^(2^hsize))-1 shifted left by haddr[log2(DATA_WIDTH/8)-1:0].
REQ-014 A read SHALL normally strobe the SRAM in its address-phase cycle (sram_cs=1, sram_we=0, word address from haddr), then complete in its data phase with zero wait states: hrdata=sram_rdata, hreadyout=1, hresp=00.
REQ-015 If a read address phase coincides with a write data phase, the write SHALL take the SRAM port, and the read SHALL be deferred: in the read's data-phase cycle hreadyout=0 and the SRAM is strobed with the registered address; in the next cycle hreadyout=1 with hrdata=sram_rdata. Read-after-write to the same word therefore returns the new data.
REQ-016 hrdata SHALL be all zeros outside a completing read data phase.
REQ-017 Control SHALL be a state machine with states IDLE, WR_DP, RD_DP, RD_STALL, ERR1, ERR2.
REQ-018 The transitions from IDLE, WR_DP, RD_DP and ERR2 SHALL be decided by the accepted transfer type: read → RD_DP; read that conflicts with a write data phase → RD_STALL; write → WR_DP; error → ERR1; none → IDLE.
REQ-019 RD_STALL SHALL go to RD_DP, and ERR1 SHALL go to ERR2; neither state accepts a new transfer, because hready=0 in both.
REQ-020 hsel=0 during a pending data phase SHALL NOT abort that data phase.
REQ-021 No SRAM strobe SHALL occur in RD_STALL's successor cycle other than the deferred read already issued.

Reset
REQ-022 Assertion of hreset_n=0 SHALL immediately, at any time including mid-transfer or mid-ERROR, force: state=IDLE, hreadyout=1, hresp=00, hrdata=0, sram_cs=0, sram_we=0, sram_wbe=0, and clear the pending-transfer registers.
REQ-023 The first transfer after reset deassertion SHALL be accepted at the first hclk edge that meets REQ-008.

Structure
REQ-024 A shared package ahb2_pkg SHALL hold the htrans encodings (IDLE/BUSY/NONSEQ/SEQ), the hresp encodings (OKAY=00, ERROR=01, RETRY=10, SPLIT=11), the hsize encodings, and the slave state enum.
REQ-025 One combinational sub-module, ahb2_wbe_gen, SHALL compute sram_wbe and the alignment-error flag from the address low bits and hsize.

Verification
REQ-026 Scenario: write word 0xDEADBEEF at 0x010, then read 0x010 back-to-back → the write takes 0 waits; the read takes 1 wait state (RD_STALL); hrdata=0xDEADBEEF, hresp=00.
REQ-027 Scenario: byte write 0xAA at 0x013 (hsize=0) → sram_wbe=1000, sram_addr=4; a word read of 0x010 returns 0xAAADBEEF.
REQ-028 Scenario: read at 0x1000 with MEM_BYTES=4096 → hresp=01/hreadyout=0, then hresp=01/hreadyout=1; sram_cs remains 0 throughout.
REQ-029 Scenario: halfword access at 0x011 → ERROR response; word access at 0x012 → ERROR response.
REQ-030 Scenario: back-to-back NONSEQ reads at 0x000 and 0x004, with an IDLE inserted → each read takes 0 waits; the IDLE gets OKAY with no strobe.
REQ-031 Scenario: assert hreset_n low during ERR1 → hreadyout=1 and hresp=00 immediately; a following write to 0x020 completes normally.
